// File: rtl/prog_clk_div_pkg.sv
// rtl/prog_clk_div_pkg.sv - shared constants and types for the programmable clock divider
package prog_clk_div_pkg;

  localparam int          CNT_W_DEFAULT = 25;
  localparam int unsigned DIV_MIN       = 1;
  localparam int unsigned CLK_HZ        = 50_000_000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/prog_clk_div_if.sv
// rtl/prog_clk_div_if.sv - control/status bundle of prog_clk_div
// Optional sync_in signal present when PROG_CLK_DIV_SYNC_EN is defined.
interface prog_clk_div_if #(
  parameter int CNT_W = prog_clk_div_pkg::CNT_W_DEFAULT
);

  logic             en;
  logic [CNT_W-1:0] div_val;
  logic             div_load;
  logic             div_ack;
  logic             div_err;
  logic             busy;
  logic             tick;
  logic             clk_out;
  logic [CNT_W-1:0] cnt_out;
`ifdef PROG_CLK_DIV_SYNC_EN
  logic             sync_in;
`endif

  modport master (
`ifdef PROG_CLK_DIV_SYNC_EN
    output sync_in,
`endif
    output en, div_val, div_load,
    input  div_ack, div_err, busy, tick, clk_out, cnt_out
  );

  modport slave (
`ifdef PROG_CLK_DIV_SYNC_EN
    input  sync_in,
`endif
    input  en, div_val, div_load,
    output div_ack, div_err, busy, tick, clk_out, cnt_out
  );

endinterface

// File: rtl/prog_clk_div_cnt.sv
// rtl/prog_clk_div_cnt.sv - period counter with terminal compare, tick and clk_out registers
module prog_clk_div_cnt #(
  parameter int CNT_W = prog_clk_div_pkg::CNT_W_DEFAULT
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] div_active_i,
  output logic             wrap_o,
  output logic             tick_o,
  output logic             clk_out_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             clk_out_q, clk_out_d;
  logic             term;

  // Equality against div_active-1 so a shrinking divisor can never be overrun.
  assign term = run_i && (cnt_q == (div_active_i - CNT_W'(1)));

  always_comb begin
    cnt_d     = cnt_q;
    tick_d    = 1'b0;
    clk_out_d = clk_out_q;
    if (run_i) begin
      if (clr_i) begin
        cnt_d     = '0;
        clk_out_d = 1'b0;
      end else if (term) begin
        cnt_d     = '0;
        tick_d    = 1'b1;
        clk_out_d = ~clk_out_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      clk_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign wrap_o    = term;
  assign tick_o    = tick_q;
  assign clk_out_o = clk_out_q;
  assign cnt_o     = cnt_q;

endmodule

// File: rtl/prog_clk_div.sv
// rtl/prog_clk_div.sv - runtime-programmable tick/clock divider with load/ack divisor handshake
// Optional PROG_CLK_DIV_SYNC_EN adds a sync_in phase-alignment input.
module prog_clk_div
  import prog_clk_div_pkg::*;
#(
  parameter int          CNT_W     = CNT_W_DEFAULT,
  parameter int unsigned DIV_RESET = CLK_HZ / 2
) (
  input  logic           clk_in,
  input  logic           rst_n,
  prog_clk_div_if.slave  bus
);

  localparam logic [CNT_W-1:0] DIV_RST_V = CNT_W'(DIV_RESET);
  localparam logic [CNT_W-1:0] DIV_MIN_V = CNT_W'(DIV_MIN);

  state_e           mode;
  logic             run;
  logic             sync_clr;
  logic             wrap;
  logic             apply;
  logic             load_ok;
  logic             load_bad;

  logic [CNT_W-1:0] div_active_q, div_active_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             ack_q, err_q;

  logic             tick_w;
  logic             clk_out_w;
  logic [CNT_W-1:0] cnt_w;

  assign mode = bus.en ? RUN : IDLE;
  assign run  = (mode == RUN);

`ifdef PROG_CLK_DIV_SYNC_EN
  assign sync_clr = bus.sync_in && run;
`else
  assign sync_clr = 1'b0;
`endif

  assign load_ok  = bus.div_load && (bus.div_val >= DIV_MIN_V);
  assign load_bad = bus.div_load && (bus.div_val <  DIV_MIN_V);
  assign apply    = wrap || sync_clr;

  // A load landing on the apply edge bypasses the pending register.
  always_comb begin
    div_active_d = div_active_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    if (load_ok) begin
      pend_d       = bus.div_val;
      pend_valid_d = 1'b1;
    end
    if (apply) begin
      pend_valid_d = 1'b0;
      if (load_ok) begin
        div_active_d = bus.div_val;
      end else if (pend_valid_q) begin
        div_active_d = pend_q;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_active_q <= DIV_RST_V;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      div_active_q <= div_active_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      ack_q        <= load_ok;
      err_q        <= load_bad;
    end
  end

  prog_clk_div_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .run_i        (run),
    .clr_i        (sync_clr),
    .div_active_i (div_active_q),
    .wrap_o       (wrap),
    .tick_o       (tick_w),
    .clk_out_o    (clk_out_w),
    .cnt_o        (cnt_w)
  );

  assign bus.div_ack = ack_q;
  assign bus.div_err = err_q;
  assign bus.busy    = pend_valid_q;
  assign bus.tick    = tick_w;
  assign bus.clk_out = clk_out_w;
  assign bus.cnt_out = cnt_w;

endmodule

// File: tb/tb_prog_clk_div.sv
// tb/tb_prog_clk_div.sv - directed self-checking bench for prog_clk_div (DIV_RESET=4, CNT_W=8)
// Sync-input section runs only when PROG_CLK_DIV_SYNC_EN is defined.
module tb_prog_clk_div;

  localparam int CNT_W = 8;

  logic clk_in = 1'b0;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;
  int m_cnt    = 0;
  int m_tick   = 0;
  int m_clk    = 0;

  always #5 clk_in = ~clk_in;

  prog_clk_div_if #(.CNT_W(CNT_W)) bus ();

  prog_clk_div #(
    .CNT_W     (CNT_W),
    .DIV_RESET (4)
  ) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock with a known divisor and compare counter, tick and clk_out.
  task automatic step_chk(input int div);
    if (m_cnt == div - 1) begin
      m_cnt  = 0;
      m_tick = 1;
      m_clk  = 1 - m_clk;
    end else begin
      m_cnt  = m_cnt + 1;
      m_tick = 0;
    end
    @(posedge clk_in); #1;
    check("cnt_out", 32'(bus.cnt_out), m_cnt);
    check("tick",    32'(bus.tick),    m_tick);
    check("clk_out", 32'(bus.clk_out), m_clk);
  endtask

  task automatic load(input int val);
    bus.div_load = 1'b1;
    bus.div_val  = CNT_W'(val);
  endtask

  task automatic unload();
    bus.div_load = 1'b0;
    bus.div_val  = '0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cnt"},  32'(bus.cnt_out), 0);
    check({tag, "_tick"}, 32'(bus.tick),    0);
    check({tag, "_clk"},  32'(bus.clk_out), 0);
    check({tag, "_busy"}, 32'(bus.busy),    0);
    check({tag, "_ack"},  32'(bus.div_ack), 0);
    check({tag, "_err"},  32'(bus.div_err), 0);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.div_load = 1'b0;
    bus.div_val  = '0;
`ifdef PROG_CLK_DIV_SYNC_EN
    bus.sync_in  = 1'b0;
`endif
    repeat (3) @(posedge clk_in);
    #1;
    check_idle_outputs("reset");

    // Reset divisor 4: tick every 4 cycles, clk_out period 8.
    rst_n  = 1'b1;
    bus.en = 1'b1;
    for (int i = 0; i < 16; i++) step_chk(4);

    // Mid-period load of 2 at cnt=1; current period stays 4.
    step_chk(4);
    load(2);
    step_chk(4);
    check("ack_mid",  32'(bus.div_ack), 1);
    check("busy_mid", 32'(bus.busy),    1);
    unload();
    step_chk(4);
    check("ack_drop", 32'(bus.div_ack), 0);
    check("busy_hold", 32'(bus.busy),   1);
    step_chk(4);
    check("busy_wrap", 32'(bus.busy),   0);
    for (int i = 0; i < 6; i++) step_chk(2);

    // Rejected load of 0.
    load(0);
    step_chk(2);
    check("err_pulse", 32'(bus.div_err), 1);
    check("err_noack", 32'(bus.div_ack), 0);
    check("err_nobusy", 32'(bus.busy),   0);
    unload();
    step_chk(2);
    check("err_drop", 32'(bus.div_err), 0);
    for (int i = 0; i < 4; i++) step_chk(2);

    // Divisor 1: tick continuously high, clk_out at half rate.
    load(1);
    step_chk(2);
    check("ack_div1", 32'(bus.div_ack), 1);
    unload();
    step_chk(2);
    for (int i = 0; i < 6; i++) step_chk(1);

    // Load on a terminal cycle takes effect at that same wrap.
    load(3);
    step_chk(1);
    check("ack_bypass",  32'(bus.div_ack), 1);
    check("busy_bypass", 32'(bus.busy),    0);
    unload();
    for (int i = 0; i < 6; i++) step_chk(3);

    // Overwrite: 5 then 6 on consecutive cycles, latest wins.
    load(5);
    step_chk(3);
    check("ack_ow1", 32'(bus.div_ack), 1);
    load(6);
    step_chk(3);
    check("ack_ow2",  32'(bus.div_ack), 1);
    check("busy_ow2", 32'(bus.busy),    1);
    unload();
    step_chk(3);
    check("busy_ow_wrap", 32'(bus.busy), 0);
    for (int i = 0; i < 12; i++) step_chk(6);

    // Back to 4, then freeze at cnt=2 for 10 cycles.
    load(4);
    step_chk(6);
    unload();
    for (int i = 0; i < 5; i++) step_chk(6);
    step_chk(4);
    step_chk(4);
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_in); #1;
      check("frz_cnt",  32'(bus.cnt_out), 2);
      check("frz_tick", 32'(bus.tick),    0);
      check("frz_clk",  32'(bus.clk_out), m_clk);
    end
    bus.en = 1'b1;
    step_chk(4);
    step_chk(4);

    // Switch to 7, leave 3 pending, then reset between edges.
    load(7);
    step_chk(4);
    unload();
    for (int i = 0; i < 3; i++) step_chk(4);
    load(3);
    step_chk(7);
    check("busy_pre_rst", 32'(bus.busy), 1);
    unload();
    step_chk(7);
    #3;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    @(posedge clk_in); #1;
    rst_n = 1'b1;
    m_cnt = 0;
    m_clk = 0;
    for (int i = 0; i < 8; i++) step_chk(4);
    check("busy_post_rst", 32'(bus.busy), 0);

`ifdef PROG_CLK_DIV_SYNC_EN
    // Divisor 8, sync pulse at cnt=3 with clk_out high.
    load(8);
    step_chk(4);
    unload();
    for (int i = 0; i < 3; i++) step_chk(4);
    for (int i = 0; i < 3; i++) step_chk(8);
    bus.sync_in = 1'b1;
    @(posedge clk_in); #1;
    bus.sync_in = 1'b0;
    check("sync_cnt",  32'(bus.cnt_out), 0);
    check("sync_clk",  32'(bus.clk_out), 0);
    check("sync_tick", 32'(bus.tick),    0);
    m_cnt = 0;
    m_clk = 0;
    for (int i = 0; i < 8; i++) step_chk(8);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_clk_div.md
Name: prog_clk_div

Overview:
- Runtime-programmable clock divider and tick generator. It is the parametrised successor to the fixed 50 MHz to 1 Hz divider.
- It produces a 1-cycle `tick` enable and a 50%-duty `clk_out` toggle. The divisor is loaded through a load/ack handshake and applied glitch-free at a period boundary.
- It feeds traffic-light timing FSMs, display refresh and debounce logic.
- All outputs are synchronous to `clk_in`. `clk_out` is a slow clock-like signal and must not be used as a clock.

Parameters:
- CNT_W, 25, counter and divisor width in bits.
- DIV_RESET, 25_000_000, divisor after reset: input cycles per half-period of `clk_out` (legal range 1..2^CNT_W-1).

Ports:
- clk_in  input  1  system clock (50 MHz).
- rst_n  input  1  reset; asynchronous assert, active-low.
- en  input  1  count enable; 0 freezes the counter.
- div_val  input  CNT_W  requested divisor.
- div_load  input  1  1-cycle request to load `div_val`.
- div_ack  output  1  1-cycle pulse: load accepted.
- div_err  output  1  1-cycle pulse: load rejected (`div_val`==0).
- busy  output  1  a pending divisor is waiting for a period boundary.
- tick  output  1  1-cycle pulse at each terminal count.
- clk_out  output  1  toggles at each terminal count; period = 2*divisor cycles.
- cnt_out  output  CNT_W  current counter value (debug/visibility).

Behaviour:
- Interface: one clock, `clk_in`. Reset `rst_n` is asynchronous and active-low.
- Reset values:
  - cnt=0; div_active=DIV_RESET; pend_valid=0.
  - tick=0, clk_out=0, div_ack=0, div_err=0, busy=0, cnt_out=0.
- States:
  - IDLE (en=0): cnt, clk_out and pending are held; tick=0.
  - RUN (en=1): cnt increments by 1 each cycle.
  - Transition IDLE to RUN resumes from the held cnt. There is no restart.
- Terminal count (RUN and cnt==div_active-1), all in the same edge:
  - cnt<=0.
  - tick<=1 for exactly one cycle (registered; asserted the cycle after cnt showed div_active-1).
  - clk_out<=~clk_out.
  - If pend_valid, then div_active<=pend and pend_valid<=0.
- div_active==1: tick stays high continuously; clk_out toggles every cycle (clk_in/2).
- Load handshake:
  - div_load=1 with div_val>=1: pend<=div_val, pend_valid<=1, and div_ack pulses the next cycle.
  - div_load=1 with div_val==0: div_err pulses the next cycle. No state changes.
  - A load while already pending overwrites the pending value (latest wins) and acks again.
- Simultaneous load and terminal count: the newly loaded value is applied at this wrap (bypass), pend_valid ends 0, and div_ack still pulses.
- While en=0, a pending value stays pending until the first terminal count after RUN resumes.
- `busy` = pend_valid (registered).
- Arithmetic: cnt is never compared against a value below its current value. The divisor changes only when cnt==0. Width is CNT_W unsigned, and the terminal compare uses div_active-1 (div_active>=1 guaranteed).
- Reset mid-operation: all registers return to reset values immediately and any pending divisor is discarded.

Optional Feature:
- Macro: PROG_CLK_DIV_SYNC_EN.
- Defined:
  - Adds input `sync_in` (1 bit).
  - `sync_in`=1 in RUN: next edge cnt<=0, clk_out<=0, tick<=0, and any pending divisor is applied.
  - `sync_in` has priority over terminal count.
  - `sync_in` is ignored in IDLE.
  - Used to phase-align multiple dividers.
- Undefined: the port is absent and there is no resynchronisation path.

Decomposition:
- Package prog_clk_div_pkg holds:
  - CNT_W_DEFAULT=25.
  - DIV_MIN=1.
  - State enum {IDLE, RUN}.
  - Helper constant for the 50 MHz clock rate (CLK_HZ=50_000_000).
- One sub-module is natural: prog_clk_div_cnt. It contains the counter, terminal compare and tick/clk_out registers, and takes div_active and a sync/clear input.
- The handshake/pending logic lives in the top module.

Test Plan:
- Reset value: DIV_RESET=4, en=1 held → tick every 4 cycles, clk_out period 8 cycles, first tick 4 cycles after reset release.
- Mid-period load: load div_val=2 at cnt=1 → div_ack next cycle, busy=1 until wrap. The current period stays 4; following ticks come every 2 cycles and busy returns to 0.
- Rejected load: div_val=0 → div_err 1-cycle pulse, no ack, tick spacing unchanged. Then load 1 → tick held high continuously and clk_out toggles every cycle.
- Load on terminal cycle plus overwrite: load 3 on the terminal cycle → very next period is 3. Load 5 then 6 on consecutive cycles before a wrap → two acks and next period is 6.
- Enable freeze: deassert en at cnt=2 for 10 cycles → cnt_out holds 2, no tick, clk_out steady. On resume, tick comes 2 cycles later (DIV=4).
- Async reset and option: drop rst_n mid-period with a pending load → all outputs 0 without waiting for an edge, pend discarded, divisor back to DIV_RESET. With PROG_CLK_DIV_SYNC_EN, a sync_in pulse at cnt=3 (DIV=8) → cnt 0, clk_out 0, no tick.
